// File: rtl/ttl_mux_scan_sequencer_if.sv
// Bus between the scan sequencer and the 4-bit source mux/latch stage.
// Carries start/skip_mask/g_in in, mux controls and sample stream out.
`timescale 1ns/1ps
interface ttl_mux_scan_sequencer_if #(
  parameter int W = 4
);
  logic         start;
  logic [7:0]   skip_mask;
  logic [W-1:0] g_in;
  logic [3:0]   sel;
  logic         sel2;
  logic [1:0]   sel3;
  logic         sel1;
  logic         clr;
  logic         busy;
  logic [W-1:0] g_out;
  logic [2:0]   slot_id;
  logic         g_valid;
  logic         done;

  modport master (
    input  start, skip_mask, g_in,
    output sel, sel2, sel3, sel1, clr,
    output busy, g_out, slot_id, g_valid, done
  );

  modport slave (
    output start, skip_mask, g_in,
    input  sel, sel2, sel3, sel1, clr,
    input  busy, g_out, slot_id, g_valid, done
  );
endinterface

// File: rtl/ttl_mux_scan_sequencer.sv
// Scans up to eight mux source slots, dwells DWELL cycles per slot,
// then samples g_in and emits it with slot_id and a one-cycle g_valid.
// Ports: clk, reset (async, active-high), bus (master modport):
//   in : start, skip_mask[7:0], g_in[W-1:0]
//   out: sel[3:0], sel2, sel3[1:0], sel1, clr, busy,
//        g_out[W-1:0], slot_id[2:0], g_valid, done
// Optional: define SEQ_LOOP_EN to let a start held in the last
// SAMPLE restart the scan (re-latching skip_mask) without DONE.
`timescale 1ns/1ps
module ttl_mux_scan_sequencer #(
  parameter int W     = 4,
  parameter int DWELL = 2
) (
  input logic clk,
  input logic reset,
  ttl_mux_scan_sequencer_if.master bus
);

`ifdef SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam logic [3:0] DWELL_M1 = 4'(DWELL - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]   mask_q;
  logic [2:0]   ptr;
  logic [3:0]   cnt;
  logic [W-1:0] g_q;
  logic [2:0]   slot_q;
  logic         valid_q;

  logic [2:0] first_slot;
  logic [2:0] nxt_slot;
  logic       has_nxt;
  logic       reloop;

  logic [3:0] sel_c;
  logic       sel2_c;
  logic [1:0] sel3_c;
  logic       sel1_c;

  // Lowest unskipped slot overall, and lowest one above ptr.
  // Scanning downward leaves the lowest match in the result.
  always_comb begin
    first_slot = '0;
    nxt_slot   = '0;
    has_nxt    = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!mask_q[i]) begin
        first_slot = 3'(i);
      end
      if (!mask_q[i] && (4'(i) > {1'b0, ptr})) begin
        nxt_slot = 3'(i);
        has_nxt  = 1'b1;
      end
    end
  end

  // Restart only when the new mask leaves something to scan.
  assign reloop = LOOP_EN && bus.start
                  && (bus.skip_mask != 8'hFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.skip_mask == 8'hFF) begin
            state_d = DONE;
          end else begin
            state_d = CLEAR;
          end
        end
      end
      CLEAR: state_d = DRIVE;
      DRIVE: begin
        if (cnt == 4'd0) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (has_nxt) begin
          state_d = DRIVE;
        end else if (reloop) begin
          state_d = CLEAR;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q  <= '0;
      ptr     <= '0;
      cnt     <= '0;
      g_q     <= '0;
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            mask_q <= bus.skip_mask;
          end
        end
        CLEAR: begin
          ptr <= first_slot;
          cnt <= DWELL_M1;
        end
        DRIVE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        SAMPLE: begin
          g_q     <= bus.g_in;
          slot_q  <= ptr;
          valid_q <= 1'b1;
          if (has_nxt) begin
            ptr <= nxt_slot;
            cnt <= DWELL_M1;
          end else if (reloop) begin
            mask_q <= bus.skip_mask;
          end
        end
        default: ;
      endcase
    end
  end

  // Controls are live only while a slot is driven or sampled.
  // The latch load fires only in the first DRIVE cycle, which is
  // the one where the counter still holds its loaded value.
  always_comb begin
    sel_c  = 4'b0000;
    sel2_c = 1'b0;
    sel3_c = 2'b00;
    sel1_c = 1'b0;
    if (state_q == DRIVE || state_q == SAMPLE) begin
      unique case (ptr)
        3'd0: sel_c = 4'b0001;
        3'd1: begin
          sel_c  = 4'b0010;
          sel1_c = (state_q == DRIVE) && (cnt == DWELL_M1);
        end
        3'd2: sel_c = 4'b0100;
        3'd3: begin
          sel_c  = 4'b0100;
          sel2_c = 1'b1;
        end
        default: begin
          sel_c  = 4'b1000;
          sel3_c = ptr[1:0];
        end
      endcase
    end
  end

  assign bus.sel     = sel_c;
  assign bus.sel2    = sel2_c;
  assign bus.sel3    = sel3_c;
  assign bus.sel1    = sel1_c;
  assign bus.clr     = reset | (state_q == CLEAR);
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.g_out   = g_q;
  assign bus.slot_id = slot_q;
  assign bus.g_valid = valid_q;

endmodule

// File: tb/tb_ttl_mux_scan_sequencer.sv
// Directed bench for ttl_mux_scan_sequencer with a behavioural mux
// model feeding g_in back from the select controls.
`timescale 1ns/1ps
module tb_ttl_mux_scan_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ttl_mux_scan_sequencer_if #(.W(4)) bus_a ();
  ttl_mux_scan_sequencer_if #(.W(4)) bus_b ();

  logic [3:0] base_a;
  logic [3:0] base_b;

  function automatic logic [3:0] mux_slot(
    input logic [3:0] s,
    input logic       s2,
    input logic [1:0] s3
  );
    if (s == 4'b0001) return 4'd0;
    if (s == 4'b0010) return 4'd1;
    if (s == 4'b0100) return s2 ? 4'd3 : 4'd2;
    if (s == 4'b1000) return 4'd4 + {2'b00, s3};
    return 4'd0;
  endfunction

  function automatic logic [3:0] slot_sel(input int sl);
    if (sl == 0) return 4'b0001;
    if (sl == 1) return 4'b0010;
    if (sl < 4)  return 4'b0100;
    return 4'b1000;
  endfunction

  assign bus_a.g_in = base_a
    + mux_slot(bus_a.sel, bus_a.sel2, bus_a.sel3);
  assign bus_b.g_in = base_b
    + mux_slot(bus_b.sel, bus_b.sel2, bus_b.sel3);

  ttl_mux_scan_sequencer #(.W(4), .DWELL(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  ttl_mux_scan_sequencer #(.W(4), .DWELL(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.start = 1'b0;
    bus_a.skip_mask = 8'h00;
    bus_b.start = 1'b0;
    bus_b.skip_mask = 8'h00;
    base_a = 4'h0;
    base_b = 4'h0;
    cyc();
    cyc();
    checks++;
    if ({bus_a.clr, bus_a.busy, bus_a.done, bus_a.g_valid}
        !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 1000",
        {bus_a.clr, bus_a.busy, bus_a.done, bus_a.g_valid});
    end
    checks++;
    if ({bus_a.sel, bus_a.sel2, bus_a.sel3, bus_a.sel1}
        !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 00000000",
        {bus_a.sel, bus_a.sel2, bus_a.sel3, bus_a.sel1});
    end
    checks++;
    if ({bus_a.g_out, bus_a.slot_id} !== 7'd0) begin
      errors++;
      $display("FAIL reset_data got %h/%0d exp 0/0",
        bus_a.g_out, bus_a.slot_id);
    end
    checks++;
    if (bus_b.busy !== 1'b0 || bus_b.clr !== 1'b1) begin
      errors++;
      $display("FAIL reset_dut3 got busy=%b clr=%b exp 0/1",
        bus_b.busy, bus_b.clr);
    end
    reset = 1'b0;
    cyc();
    checks++;
    if (bus_a.clr !== 1'b0 || bus_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got clr=%b busy=%b exp 0/0",
        bus_a.clr, bus_a.busy);
    end
  endtask

  task automatic test_full_scan();
    logic [7:0] ev;
    logic [7:0] ov;
    int sl;
    int ph;
    base_a = 4'h0;
    bus_a.skip_mask = 8'h00;
    bus_a.start = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      cyc();
      if (c == 1) bus_a.start = 1'b0;
      ev = '0;
      ev[7] = (c == 1);
      ev[6] = (c <= 26);
      ev[5] = (c == 26);
      ev[4] = (c >= 5) && (c <= 26) && ((c - 5) % 3 == 0);
      if (c >= 2 && c <= 25) begin
        sl = (c - 2) / 3;
        ph = (c - 2) % 3;
        ev[3:0] = slot_sel(sl);
      end else begin
        sl = 0;
        ph = 1;
      end
      ov = {bus_a.clr, bus_a.busy, bus_a.done,
            bus_a.g_valid, bus_a.sel};
      checks++;
      if (ov !== ev) begin
        errors++;
        $display("FAIL full_ctrl c=%0d got %b exp %b", c, ov, ev);
      end
      checks++;
      if (bus_a.sel1 !== (c >= 2 && c <= 25 && sl == 1 && ph == 0)) begin
        errors++;
        $display("FAIL full_sel1 c=%0d got %b", c, bus_a.sel1);
      end
      if (ev[4]) begin
        checks++;
        if (bus_a.slot_id !== 3'((c - 5) / 3)
            || bus_a.g_out !== 4'((c - 5) / 3)) begin
          errors++;
          $display("FAIL full_data c=%0d got %0d/%h exp %0d/%h",
            c, bus_a.slot_id, bus_a.g_out,
            (c - 5) / 3, (c - 5) / 3);
        end
      end
    end
  endtask

  task automatic test_skip_all();
    bus_a.skip_mask = 8'hFF;
    bus_a.start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      bus_a.start = 1'b0;
      checks++;
      if ({bus_a.clr, bus_a.busy, bus_a.done, bus_a.g_valid,
           bus_a.sel} !== {1'b0, c == 1, c == 1, 1'b0, 4'b0000}) begin
        errors++;
        $display("FAIL skip_all c=%0d got %b", c,
          {bus_a.clr, bus_a.busy, bus_a.done, bus_a.g_valid,
           bus_a.sel});
      end
    end
  endtask

  task automatic test_slot1_dwell3();
    base_b = 4'h8;
    bus_b.skip_mask = 8'b1111_1101;
    bus_b.start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      bus_b.start = 1'b0;
      checks++;
      if (bus_b.sel !== ((c >= 2 && c <= 5) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL slot1_sel c=%0d got %b", c, bus_b.sel);
      end
      checks++;
      if (bus_b.sel1 !== (c == 2)) begin
        errors++;
        $display("FAIL slot1_sel1 c=%0d got %b exp %b",
          c, bus_b.sel1, c == 2);
      end
      checks++;
      if ({bus_b.g_valid, bus_b.done, bus_b.clr}
          !== {c == 6, c == 6, c == 1}) begin
        errors++;
        $display("FAIL slot1_flags c=%0d got %b", c,
          {bus_b.g_valid, bus_b.done, bus_b.clr});
      end
      if (c == 6) begin
        checks++;
        if (bus_b.slot_id !== 3'd1 || bus_b.g_out !== 4'h9) begin
          errors++;
          $display("FAIL slot1_data got %0d/%h exp 1/9",
            bus_b.slot_id, bus_b.g_out);
        end
      end
    end
  endtask

  task automatic test_slot7();
    base_a = 4'h3;
    bus_a.skip_mask = 8'b0111_1111;
    bus_a.start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      bus_a.start = 1'b0;
      checks++;
      if ({bus_a.sel, bus_a.sel3} !== ((c >= 2 && c <= 4)
          ? 6'b1000_11 : 6'b0000_00)) begin
        errors++;
        $display("FAIL slot7_ctrl c=%0d got %b", c,
          {bus_a.sel, bus_a.sel3});
      end
      checks++;
      if ({bus_a.g_valid, bus_a.done} !== {c == 5, c == 5}) begin
        errors++;
        $display("FAIL slot7_flags c=%0d got %b", c,
          {bus_a.g_valid, bus_a.done});
      end
      if (c == 5) begin
        checks++;
        if (bus_a.slot_id !== 3'd7 || bus_a.g_out !== 4'hA) begin
          errors++;
          $display("FAIL slot7_data got %0d/%h exp 7/a",
            bus_a.slot_id, bus_a.g_out);
        end
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    base_a = 4'h0;
    bus_a.skip_mask = 8'h00;
    bus_a.start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      cyc();
      bus_a.start = 1'b0;
    end
    checks++;
    if ({bus_a.sel, bus_a.sel2} !== 5'b0100_1) begin
      errors++;
      $display("FAIL mid_slot3 got %b exp 01001",
        {bus_a.sel, bus_a.sel2});
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus_a.clr, bus_a.busy, bus_a.done, bus_a.g_valid,
         bus_a.sel, bus_a.sel2, bus_a.sel3, bus_a.sel1}
        !== 12'b1000_0000_0000) begin
      errors++;
      $display("FAIL mid_async_ctrl got %b", {bus_a.clr,
        bus_a.busy, bus_a.done, bus_a.g_valid, bus_a.sel,
        bus_a.sel2, bus_a.sel3, bus_a.sel1});
    end
    checks++;
    if (bus_a.g_out !== 4'h0 || bus_a.slot_id !== 3'd0) begin
      errors++;
      $display("FAIL mid_async_data got %h/%0d exp 0/0",
        bus_a.g_out, bus_a.slot_id);
    end
    for (int c = 0; c < 3; c++) begin
      cyc();
      checks++;
      if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_hold c=%0d got done=%b busy=%b",
          c, bus_a.done, bus_a.busy);
      end
    end
    reset = 1'b0;
    cyc();
    base_a = 4'h5;
    bus_a.skip_mask = 8'b1111_1011;
    bus_a.start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      bus_a.start = 1'b0;
      checks++;
      if ({bus_a.clr, bus_a.g_valid, bus_a.done, bus_a.busy}
          !== {c == 1, c == 5, c == 5, c <= 5}) begin
        errors++;
        $display("FAIL mid_rescan c=%0d got %b", c, {bus_a.clr,
          bus_a.g_valid, bus_a.done, bus_a.busy});
      end
      if (c == 5) begin
        checks++;
        if (bus_a.slot_id !== 3'd2 || bus_a.g_out !== 4'h7) begin
          errors++;
          $display("FAIL mid_rescan_data got %0d/%h exp 2/7",
            bus_a.slot_id, bus_a.g_out);
        end
      end
    end
  endtask

`ifdef SEQ_LOOP_EN
  task automatic test_back_to_back();
    base_a = 4'h2;
    bus_a.skip_mask = 8'b1111_1110;
    bus_a.start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      cyc();
      if (c == 13) bus_a.start = 1'b0;
      checks++;
      if ({bus_a.g_valid, bus_a.done, bus_a.busy}
          !== {(c >= 5) && ((c - 5) % 4 == 0), c == 17, c <= 17}) begin
        errors++;
        $display("FAIL loop c=%0d got %b", c,
          {bus_a.g_valid, bus_a.done, bus_a.busy});
      end
      if (bus_a.g_valid === 1'b1) begin
        checks++;
        if (bus_a.slot_id !== 3'd0 || bus_a.g_out !== 4'h2) begin
          errors++;
          $display("FAIL loop_data c=%0d got %0d/%h exp 0/2",
            c, bus_a.slot_id, bus_a.g_out);
        end
      end
    end
  endtask
`else
  task automatic test_back_to_back();
    base_a = 4'h2;
    bus_a.skip_mask = 8'b1111_1110;
    bus_a.start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      if (c == 5) bus_a.start = 1'b0;
      checks++;
      if ({bus_a.g_valid, bus_a.done, bus_a.busy, bus_a.clr}
          !== {c == 5, c == 5, c <= 5, c == 1}) begin
        errors++;
        $display("FAIL busy_start c=%0d got %b", c, {bus_a.g_valid,
          bus_a.done, bus_a.busy, bus_a.clr});
      end
      if (c == 5) begin
        checks++;
        if (bus_a.slot_id !== 3'd0 || bus_a.g_out !== 4'h2) begin
          errors++;
          $display("FAIL busy_start_data got %0d/%h exp 0/2",
            bus_a.slot_id, bus_a.g_out);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_scan();
    test_skip_all();
    test_slot1_dwell3();
    test_slot7();
    test_reset_mid_scan();
    cyc();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
